// File: rtl/cmp_pkg.sv
// cmp_pkg: comparison select encoding shared by decoder, branch unit and compare_arbiter
package cmp_pkg;
  typedef enum logic [3:0] {
    CMP_EQ  = 4'd0,
    CMP_NE  = 4'd1,
    CMP_LT  = 4'd2,
    CMP_LTU = 4'd3,
    CMP_GE  = 4'd4,
    CMP_GEU = 4'd5
  } cmp_sel_e;
  function automatic logic is_valid_sel(input int unsigned s);
    return s <= int'(CMP_GEU);
  endfunction
endpackage

// File: rtl/compare_core.sv
// compare_core: combinational RISC-V compare; undefined select yields bit 0 with err set
module compare_core
  import cmp_pkg::*;
#(
  parameter int dataWidth   = 32,
  parameter int selectWidth = 4
) (
  input  logic [dataWidth-1:0]   a_i,
  input  logic [dataWidth-1:0]   b_i,
  input  logic [selectWidth-1:0] sel_i,
  output logic                   bit_o,
  output logic                   err_o
);
  logic eq, lt, ltu;
  always_comb begin
    eq    = a_i == b_i;
    lt    = $signed(a_i) < $signed(b_i);
    ltu   = a_i < b_i;
    err_o = !is_valid_sel(32'(sel_i));
    bit_o = err_o                         ? 1'b0 :
            sel_i == selectWidth'(CMP_EQ)  ? eq   :
            sel_i == selectWidth'(CMP_NE)  ? !eq  :
            sel_i == selectWidth'(CMP_LT)  ? lt   :
            sel_i == selectWidth'(CMP_LTU) ? ltu  :
            sel_i == selectWidth'(CMP_GE)  ? !lt  : !ltu;
  end
endmodule

// File: rtl/compare_arbiter.sv
// compare_arbiter: round-robin share of one compare_core between branch (port 0) and
// set-compare (port 1), with a single flushable registered output stage.
module compare_arbiter
  import cmp_pkg::*;
#(
  parameter int dataWidth   = 32,
  parameter int selectWidth = 4,
  parameter int tagWidth    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [2*dataWidth-1:0]   req_a,
  input  logic [2*dataWidth-1:0]   req_b,
  input  logic [2*selectWidth-1:0] req_sel,
  input  logic [2*tagWidth-1:0]    req_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [dataWidth-1:0]     out_result,
  output logic                     out_taken,
  output logic                     out_id,
  output logic [tagWidth-1:0]      out_tag,
  output logic                     out_err
);
  logic                   valid_q, valid_d, taken_q, taken_d, id_q, id_d;
  logic                   err_q, err_d, last_q, last_d;
  logic [tagWidth-1:0]    tag_q, tag_d;
  logic                   free, gnt, accept, cmp_bit, cmp_err;
  logic [dataWidth-1:0]   a, b;
  logic [selectWidth-1:0] sel;
  logic [tagWidth-1:0]    tag;
  // contention goes to the port that did not win last; a lone request wins outright
  assign gnt       = &req_valid ? !last_q : req_valid[1];
  assign free      = !valid_q || out_ready;
  assign req_ready = (free && !flush && !reset && |req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign accept    = |req_ready;
  assign a   = gnt ? req_a[2*dataWidth-1:dataWidth]       : req_a[dataWidth-1:0];
  assign b   = gnt ? req_b[2*dataWidth-1:dataWidth]       : req_b[dataWidth-1:0];
  assign sel = gnt ? req_sel[2*selectWidth-1:selectWidth] : req_sel[selectWidth-1:0];
  assign tag = gnt ? req_tag[2*tagWidth-1:tagWidth]       : req_tag[tagWidth-1:0];
  compare_core #(
    .dataWidth  (dataWidth),
    .selectWidth(selectWidth)
  ) u_core (
    .a_i  (a),
    .b_i  (b),
    .sel_i(sel),
    .bit_o(cmp_bit),
    .err_o(cmp_err)
  );
  always_comb begin
    valid_d = flush ? 1'b0 : accept ? 1'b1 : valid_q && !out_ready;
    taken_d = accept ? cmp_bit : taken_q;
    err_d   = accept ? cmp_err : err_q;
    id_d    = accept ? gnt : id_q;
    tag_d   = accept ? tag : tag_q;
    last_d  = accept ? gnt : last_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
      id_q    <= 1'b0;
      tag_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      valid_q <= valid_d;
      taken_q <= taken_d;
      err_q   <= err_d;
      id_q    <= id_d;
      tag_q   <= tag_d;
      last_q  <= last_d;
    end
  end
  assign out_valid  = valid_q;
  assign out_taken  = taken_q;
  assign out_err    = err_q;
  assign out_id     = id_q;
  assign out_tag    = tag_q;
  assign out_result = {{(dataWidth-1){1'b0}}, taken_q};
endmodule
